// File: rtl/squid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : squid_pkg
// Brief    : GF(2^4) types, field multiply and parity-check matrix for SQUID.
// Revision : 1.0
// ============================================================================
package squid_pkg;

  localparam int SYM_W = 4;
  localparam logic [SYM_W:0] GF_POLY = 5'b10011;  // x^4 + x + 1

  localparam int H_NUM_SYN = 4;
  localparam int H_NUM_SYM = 12;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam sym_t H_MAT [H_NUM_SYN][H_NUM_SYM] = '{
    '{4'd9,  4'd13, 4'd15, 4'd14, 4'd7, 4'd10, 4'd5,  4'd11, 4'd12, 4'd6, 4'd3,  4'd8},
    '{4'd13, 4'd14, 4'd10, 4'd11, 4'd6, 4'd8,  4'd2,  4'd9,  4'd15, 4'd7, 4'd5,  4'd12},
    '{4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10},
    '{4'd14, 4'd11, 4'd8,  4'd9,  4'd7, 4'd12, 4'd4,  4'd13, 4'd10, 4'd6, 4'd2,  4'd15}
  };

  // Shift-and-add multiply, reducing by GF_POLY whenever the running term overflows.
  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p;
    sym_t t;
    logic carry;
    p = '0;
    t = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ t;
      carry = t[SYM_W-1];
      t = {t[SYM_W-2:0], 1'b0};
      if (carry) t = t ^ GF_POLY[SYM_W-1:0];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/squid_syndrome_accum_gfmult.sv
`default_nettype none
// ============================================================================
// Module   : squid_syndrome_accum_gfmult
// Brief    : Combinational GF(2^SYM_W) multiplier used per lane per syndrome.
// Revision : 1.0
// ============================================================================
module squid_syndrome_accum_gfmult
  import squid_pkg::*;
(
  input  sym_t i_a,
  input  sym_t i_b,
  output sym_t o_p
);

  assign o_p = gf_mul(i_a, i_b);

endmodule
`default_nettype wire

// File: rtl/squid_syndrome_accum.sv
`default_nettype none
// ============================================================================
// Module   : squid_syndrome_accum
// Brief    : Streaming syndrome generator; accumulates S[k] over beats, then holds.
// Revision : 1.0
// ============================================================================
module squid_syndrome_accum #(
  parameter int SYM_W        = 4,
  parameter int NUM_SYM      = 12,
  parameter int NUM_SYN      = 4,
  parameter int SYM_PER_BEAT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SYM_PER_BEAT*SYM_W-1:0] in_sym,
  input  logic                          flush,
  output logic                          syn_valid,
  input  logic                          syn_ready,
  output logic [NUM_SYN*SYM_W-1:0]      syn,
  output logic                          syn_zero
);
  import squid_pkg::*;

  localparam int c_num_beats = NUM_SYM / SYM_PER_BEAT;
  localparam int c_cnt_w     = (c_num_beats > 1) ? $clog2(c_num_beats) : 1;

  if ((NUM_SYM % SYM_PER_BEAT) != 0) begin : g_chk_div
    $error("SYM_PER_BEAT must divide NUM_SYM");
  end
  if (SYM_W != squid_pkg::SYM_W) begin : g_chk_symw
    $error("SYM_W must match the field width of squid_pkg");
  end
  if ((NUM_SYN > H_NUM_SYN) || (NUM_SYM > H_NUM_SYM)) begin : g_chk_hmat
    $error("H_MAT is too small for NUM_SYN/NUM_SYM");
  end

  state_t                          r_state;
  state_t                          w_state_next;
  logic [c_cnt_w-1:0]              r_beat_cnt;
  logic [NUM_SYN-1:0][SYM_W-1:0]   r_acc;
  logic [NUM_SYN-1:0][SYM_W-1:0]   w_acc_next;
  logic [NUM_SYN-1:0][SYM_W-1:0]   r_syn;
  logic                            r_syn_zero;
  logic [SYM_W-1:0]                w_prod [NUM_SYN][SYM_PER_BEAT];
  logic                            w_fire;
  logic                            w_last;

  assign in_ready  = (r_state == ST_ACCUM) | syn_ready;
  assign w_fire    = in_valid & in_ready & ~flush;
  assign w_last    = (r_beat_cnt == c_cnt_w'(c_num_beats - 1));
  assign syn_valid = (r_state == ST_HOLD);
  assign syn       = r_syn;
  assign syn_zero  = r_syn_zero;

  // H coefficients are constants, so each mux + multiplier folds to XOR logic.
  for (genvar k = 0; k < NUM_SYN; k++) begin : g_syn
    for (genvar i = 0; i < SYM_PER_BEAT; i++) begin : g_lane
      logic [SYM_W-1:0] w_coef;

      always_comb begin
        w_coef = '0;
        for (int b = 0; b < c_num_beats; b++) begin
          if (r_beat_cnt == c_cnt_w'(b)) w_coef = H_MAT[k][b*SYM_PER_BEAT+i];
        end
      end

      squid_syndrome_accum_gfmult u_gfmult (
        .i_a (in_sym[i*SYM_W +: SYM_W]),
        .i_b (w_coef),
        .o_p (w_prod[k][i])
      );
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SYN; k++) begin
      w_acc_next[k] = r_acc[k];
      for (int i = 0; i < SYM_PER_BEAT; i++) begin
        w_acc_next[k] = w_acc_next[k] ^ w_prod[k][i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM: if (w_fire && w_last) w_state_next = ST_HOLD;
      // A last beat accepted during the handshake re-enters HOLD with no bubble.
      ST_HOLD:  if (syn_ready) w_state_next = (w_fire && w_last) ? ST_HOLD : ST_ACCUM;
      default:  w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
      r_syn      <= '0;
      r_syn_zero <= 1'b0;
    end else if (flush) begin
      r_beat_cnt <= '0;
      r_acc      <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_beat_cnt <= '0;
        r_acc      <= '0;
        r_syn      <= w_acc_next;
        r_syn_zero <= (w_acc_next == '0);
      end else begin
        r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
        r_acc      <= w_acc_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_squid_syndrome_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_squid_syndrome_accum
// Brief    : Directed table plus corner sequences and a GF model for SYM_PER_BEAT 1/4/12.
// Revision : 1.0
// ============================================================================
module tb_squid_syndrome_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        v   [3];
  logic        rdy [3];
  logic        fl  [3];
  logic        sv  [3];
  logic        sr  [3];
  logic        sz  [3];
  logic [47:0] sb  [3];
  logic [15:0] sy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  squid_syndrome_accum dut (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy[0]), .in_sym(sb[0][15:0]),
    .flush(fl[0]), .syn_valid(sv[0]), .syn_ready(sr[0]), .syn(sy[0]), .syn_zero(sz[0])
  );

  squid_syndrome_accum #(.SYM_PER_BEAT(1)) dut_spb1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy[1]), .in_sym(sb[1][3:0]),
    .flush(fl[1]), .syn_valid(sv[1]), .syn_ready(sr[1]), .syn(sy[1]), .syn_zero(sz[1])
  );

  squid_syndrome_accum #(.SYM_PER_BEAT(12)) dut_spb12 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(rdy[2]), .in_sym(sb[2]),
    .flush(fl[2]), .syn_valid(sv[2]), .syn_ready(sr[2]), .syn(sy[2]), .syn_zero(sz[2])
  );

  logic [3:0] hm [4][12] = '{
    '{4'd9,  4'd13, 4'd15, 4'd14, 4'd7, 4'd10, 4'd5,  4'd11, 4'd12, 4'd6, 4'd3,  4'd8},
    '{4'd13, 4'd14, 4'd10, 4'd11, 4'd6, 4'd8,  4'd2,  4'd9,  4'd15, 4'd7, 4'd5,  4'd12},
    '{4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10, 4'd12, 4'd8,  4'd1, 4'd15, 4'd10},
    '{4'd14, 4'd11, 4'd8,  4'd9,  4'd7, 4'd12, 4'd4,  4'd13, 4'd10, 4'd6, 4'd2,  4'd15}
  };

  // Carry-less product to 7 bits, then fold bits 6..4 back with x^4 = x + 1.
  function automatic logic [3:0] gmul(logic [3:0] a, logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
    for (int q = 6; q >= 4; q--) if (p[q]) p = p ^ (7'b0010011 << (q - 4));
    return p[3:0];
  endfunction

  function automatic logic [15:0] model(logic [47:0] cw);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 12; j++)
        s[k*4 +: 4] = s[k*4 +: 4] ^ gmul(cw[j*4 +: 4], hm[k][j]);
    return s;
  endfunction

  function automatic logic [47:0] beat_of(logic [47:0] cw, int b, int spb);
    logic [47:0] mask;
    mask = (48'h1 << (spb * 4)) - 48'h1;
    return (cw >> (b * spb * 4)) & mask;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(input int d, input logic [47:0] data);
    int n;
    v[d]  = 1'b1;
    sb[d] = data;
    n     = 0;
    @(negedge clk);
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout dut %0d: in_ready got 0 expected 1", d);
    end
    @(posedge clk);
    #1;
    v[d] = 1'b0;
  endtask

  task automatic send_cw(input int d, input logic [47:0] cw);
    int spb;
    spb = (d == 0) ? 4 : (d == 1) ? 1 : 12;
    for (int b = 0; b < 12 / spb; b++) send_beat(d, beat_of(cw, b, spb));
  endtask

  typedef struct {
    logic [47:0] cw;
    logic [15:0] syn;
    logic        zero;
  } vec_t;

  vec_t        tbl [7];
  logic [47:0] rcw;
  logic [15:0] rexp;
  int          hit_n, hit0, hit1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      v[d] = 1'b0; fl[d] = 1'b0; sr[d] = 1'b0; sb[d] = '0;
    end
    tbl[0] = '{48'h0,              16'h0000, 1'b1};
    tbl[1] = '{48'h1,              16'hEFD9, 1'b0};
    tbl[2] = '{48'h1000_0000_0000, 16'hFAC8, 1'b0};
    tbl[3] = '{48'h1_0000,         16'h7167, 1'b0};
    tbl[4] = '{48'h2,              16'hFD91, 1'b0};
    tbl[5] = '{48'h1000_0000_0001, 16'h1511, 1'b0};
    tbl[6] = '{48'h30_0000,        16'h72BD, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(sv[0]), 32'd0);
    chk("reset_syn",   32'(sy[0]), 32'd0);
    chk("reset_zero",  32'(sz[0]), 32'd0);
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      sr[0] = 1'b0;
      send_cw(0, tbl[t].cw);
      @(negedge clk);
      chk("tbl_valid", 32'(sv[0]), 32'd1);
      chk("tbl_syn",   32'(sy[0]), 32'(tbl[t].syn));
      chk("tbl_zero",  32'(sz[0]), 32'(tbl[t].zero));
      @(posedge clk); #1 sr[0] = 1'b1;
      @(negedge clk);
      chk("tbl_held", 32'(sy[0]), 32'(tbl[t].syn));
      @(posedge clk); #1 sr[0] = 1'b0;
      @(negedge clk);
      chk("tbl_release", 32'(sv[0]), 32'd0);
      @(posedge clk); #1;
    end

    // Back-pressure: the next codeword's first beat must wait.
    send_cw(0, 48'h1);
    v[0]  = 1'b1;
    sb[0] = 48'h2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_ready", 32'(rdy[0]), 32'd0);
      chk("hold_syn",   32'(sy[0]), 32'hEFD9);
      chk("hold_valid", 32'(sv[0]), 32'd1);
    end
    @(posedge clk); #1 sr[0] = 1'b1;
    send_cw(0, 48'h2);
    @(negedge clk);
    chk("hold_next_syn",   32'(sy[0]), 32'hFD91);
    chk("hold_next_valid", 32'(sv[0]), 32'd1);
    @(posedge clk); #1 sr[0] = 1'b0;

    send_cw(0, 48'h1_0000);
    fl[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 fl[0] = 1'b0;
    @(negedge clk);
    chk("flush_hold_syn",   32'(sy[0]), 32'h7167);
    chk("flush_hold_valid", 32'(sv[0]), 32'd1);
    @(posedge clk); #1 sr[0] = 1'b1;
    @(posedge clk); #1 sr[0] = 1'b0;

    sr[0] = 1'b1;
    hit_n = 0; hit0 = -1; hit1 = -1;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c < 6) begin
        v[0]  = 1'b1;
        sb[0] = beat_of((c < 3) ? 48'h1 : 48'h1000_0000_0000, c % 3, 4);
      end else begin
        v[0] = 1'b0;
      end
      @(negedge clk);
      if (c < 6) chk("b2b_ready", 32'(rdy[0]), 32'd1);
      if (sv[0]) begin
        if (hit_n == 0) hit0 = c;
        else if (hit_n == 1) hit1 = c;
        hit_n++;
        if (c == 3) chk("b2b_syn_a", 32'(sy[0]), 32'hEFD9);
        if (c == 6) chk("b2b_syn_b", 32'(sy[0]), 32'hFAC8);
      end
    end
    chk("b2b_pulses", 32'(hit_n), 32'd2);
    chk("b2b_first",  32'(hit0), 32'd3);
    chk("b2b_gap",    32'(hit1 - hit0), 32'd3);
    @(posedge clk); #1;

    send_beat(0, 48'hFFFF);
    send_beat(0, 48'hABCD);
    fl[0] = 1'b1; v[0] = 1'b1; sb[0] = 48'h1234;
    @(negedge clk);
    @(posedge clk); #1 fl[0] = 1'b0; v[0] = 1'b0;
    @(negedge clk);
    chk("flush_drop", 32'(sv[0]), 32'd0);
    @(posedge clk); #1;
    send_cw(0, 48'h1_0000);
    @(negedge clk);
    chk("flush_syn",   32'(sy[0]), 32'h7167);
    chk("flush_valid", 32'(sv[0]), 32'd1);
    @(posedge clk); #1;

    sr[0] = 1'b0;
    send_beat(0, 48'h5555);
    v[0] = 1'b1; sb[0] = 48'h3333;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(sv[0]), 32'd0);
    chk("rst_syn",   32'(sy[0]), 32'd0);
    chk("rst_zero",  32'(sz[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    v[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_no_valid", 32'(sv[0]), 32'd0);
    @(posedge clk); #1 sr[0] = 1'b1;
    send_cw(0, 48'h1);
    @(negedge clk);
    chk("rst_next_syn",   32'(sy[0]), 32'hEFD9);
    chk("rst_next_valid", 32'(sv[0]), 32'd1);
    @(posedge clk); #1 sr[0] = 1'b0;

    for (int d = 0; d < 3; d++) begin
      sr[d] = 1'b1;
      for (int n = 0; n < 6; n++) begin
        rcw  = {16'($urandom()), 32'($urandom())};
        rexp = model(rcw);
        send_cw(d, rcw);
        @(negedge clk);
        chk("rnd_syn",   32'(sy[d]), 32'(rexp));
        chk("rnd_zero",  32'(sz[d]), 32'(rexp == 16'h0));
        chk("rnd_valid", 32'(sv[d]), 32'd1);
        @(posedge clk); #1;
      end
      sr[d] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
